areg_ctx_xfer: RTL and testbench

- Context save/restore engine that masters the `areg` register file ports.
- Save: walks read address 0..15 and streams each word out on a valid/ready interface.
- Restore: accepts 16 words on a valid/ready interface and issues full-word overwrite writes to `areg`.
- Used by the sequencer for task switch and debug dump/load.

---
 rtl/areg_ctx_xfer.sv | 134 +++++++++++++
 tb/tb_areg_ctx_xfer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/areg_ctx_xfer.sv
// Context save/restore engine mastering the areg register file ports.
// Save streams areg[0..15] out on a valid/ready link; restore writes 16 streamed words back.
module areg_ctx_xfer #(
    parameter int W    = 32,
    parameter int NREG = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         save_req,
    input  logic         restore_req,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   ra,
    input  logic [W-1:0] rval,
    output logic         w,
    output logic         y,
    output logic [3:0]   wa,
    output logic [W-1:0] wval,
    output logic [W-1:0] mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, FIN} state_t;
    localparam logic [3:0] LAST_IDX = 4'(NREG - 1);

    state_t        state_q;
    logic [3:0]    idx_q, idx_d;
    logic          err_q, done_q, w_q, y_q, in_ready_q, out_valid_q, out_last_q;
    logic [3:0]    wa_q;
    logic [W-1:0]  wval_q, mask_q, out_data_q;
    logic          out_hs, in_hs, at_last;

    assign idx_d   = idx_q + 4'd1;
    assign out_hs  = out_valid_q & out_ready;
    assign in_hs   = in_valid & in_ready_q;
    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            w_q         <= 1'b0;
            y_q         <= 1'b0;
            wa_q        <= '0;
            wval_q      <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            w_q    <= 1'b0;
            mask_q <= '0;
            done_q <= 1'b0;
            y_q    <= 1'b1;
            case (state_q)
                IDLE: begin
                    // ra sits at 0 in IDLE, so word 0 is captured on acceptance
                    if (save_req) begin
                        state_q     <= SAVE;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= rval;
                        out_last_q  <= 1'b0;
                        idx_q       <= 4'd1;
                    end else if (restore_req) begin
                        state_q    <= RESTORE;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        idx_q      <= '0;
                    end
                end
                SAVE: begin
                    if (out_hs && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end else if (!out_valid_q || out_hs) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rval;
                        out_last_q  <= at_last;
                        idx_q       <= idx_d;
                    end
                end
                RESTORE: begin
                    if (in_hs) begin
                        w_q    <= 1'b1;
                        mask_q <= '1;
                        wa_q   <= idx_q;
                        wval_q <= in_data;
                        idx_q  <= idx_d;
                        if (at_last && in_last) begin
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= FIN;
                        end else if (at_last || in_last) begin
                            // framing error: the word still lands, but no done
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign ra        = (state_q == SAVE) ? idx_q : 4'd0;
    assign w         = w_q;
    assign y         = y_q;
    assign wa        = wa_q;
    assign wval      = wval_q;
    assign mask      = mask_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_areg_ctx_xfer.sv
// Bench for areg_ctx_xfer: an areg model with 0..7 -> 8..15 write mirroring feeds rval,
// and expected register contents are tracked as a plain array of last-restored words.
module tb_areg_ctx_xfer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        save_req = 1'b0, restore_req = 1'b0;
    logic        busy, done, err, w, y;
    logic [3:0]  ra, wa;
    logic [31:0] rval, wval, mask, out_data, in_data = '0;
    logic        out_valid, out_ready = 1'b0, out_last;
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem  [16] = '{default: 32'h0};
    logic [31:0] refm [16] = '{default: 32'h0};
    logic [31:0] nv;
    int pat [4] = '{1, 0, 0, 1};

    areg_ctx_xfer #(.W(32), .NREG(16)) dut (
        .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .err(err), .ra(ra), .rval(rval),
        .w(w), .y(y), .wa(wa), .wval(wval), .mask(mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last)
    );

    always #5 clk = ~clk;

    // areg: y=1 overwrites under mask, y=0 adds; writes to 0..7 are mirrored into 8..15
    assign rval = mem[ra];
    always @(posedge clk) begin
        if (w) begin
            nv = y ? ((mem[wa] & ~mask) | (wval & mask)) : (mem[wa] + (wval & mask));
            mem[wa] <= nv;
            if (!wa[3]) mem[{1'b1, wa[2:0]}] <= nv;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {24'h0, busy, done, err, w, y, out_valid, out_last, in_ready}, 32'h0);
        chk({tag, "_ra_wa"}, {24'h0, ra, wa}, 32'h0);
        chk({tag, "_mask"}, mask, 32'h0);
        chk({tag, "_wval"}, wval, 32'h0);
        chk({tag, "_odata"}, out_data, 32'h0);
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        #2;
        rst = 1'b0;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic do_save(input int mode, input bit both, input int rst_at);
        int beats = 0;
        int cyc = 0;
        logic rdy;
        save_req = 1'b1;
        restore_req = both;
        tick();
        save_req = 1'b0;
        restore_req = 1'b0;
        chk("save_lat_valid", out_valid, 1);
        chk("save_busy", busy, 1);
        chk("save_err_clr", err, 0);
        chk("save_in_ready", in_ready, 0);
        while (beats < 16 && cyc < 300) begin
            if (beats == rst_at) begin
                pulse_rst("save_rst");
                out_ready = 1'b0;
                tick();
                chk("save_rst_idle", busy, 0);
                return;
            end
            chk($sformatf("save_valid_%0d", beats), out_valid, 1);
            chk($sformatf("save_data_%0d", beats), out_data, refm[beats]);
            chk($sformatf("save_last_%0d", beats), out_last, (beats == 15) ? 1 : 0);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4][0] : 1'($urandom_range(0, 1));
            out_ready = rdy;
            restore_req = both && beats >= 3 && beats <= 5;
            tick();
            cyc++;
            if (rdy) beats++;
        end
        out_ready = 1'b0;
        restore_req = 1'b0;
        chk("save_beats", beats, 16);
        chk("save_done", done, 1);
        chk("save_fin_busy", busy, 1);
        chk("save_fin_valid", out_valid, 0);
        tick();
        chk("save_done_once", done, 0);
        chk("save_idle", busy, 0);
        chk("save_no_restore", in_ready, 0);
    endtask

    task automatic do_restore(input int n, input bit lastf, input bit gaps, input bit rnd, input int rst_at);
        logic [31:0] d [16];
        bit ok;
        for (int i = 0; i < 16; i++) d[i] = rnd ? $urandom : 32'h1000 + i;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 1);
        chk("rst_err_clr", err, 0);
        chk("rst_out_valid", out_valid, 0);
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                in_valid = 1'b0;
                tick();
                chk("rst_pre_reset_w", w, 0);
                pulse_rst("restore_rst");
                for (int j = 0; j < k; j++) begin
                    refm[j] = d[j];
                    if (j < 8) refm[j + 8] = d[j];
                end
                tick();
                chk("rst_reset_idle", busy, 0);
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                tick();
                chk("rst_gap_w", w, 0);
                chk("rst_gap_mask", mask, 0);
                chk("rst_gap_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data = d[k];
            in_last = lastf && (k == n - 1);
            tick();
            chk($sformatf("rst_w_%0d", k), w, 1);
            chk($sformatf("rst_y_%0d", k), y, 1);
            chk($sformatf("rst_wa_%0d", k), wa, k);
            chk($sformatf("rst_wval_%0d", k), wval, d[k]);
            chk($sformatf("rst_mask_%0d", k), mask, 32'hFFFF_FFFF);
            chk($sformatf("rst_ready_%0d", k), in_ready, (k == n - 1) ? 0 : 1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        ok = (n == 16) && lastf;
        chk("rst_done", done, ok);
        chk("rst_err", err, !ok);
        chk("rst_end_busy", busy, ok);
        tick();
        chk("rst_done_once", done, 0);
        chk("rst_idle", busy, 0);
        chk("rst_idle_w", w, 0);
        for (int j = 0; j < n; j++) begin
            refm[j] = d[j];
            if (j < 8) refm[j + 8] = d[j];
        end
        for (int i = 0; i < 16; i++) chk($sformatf("areg_%0d", i), mem[i], refm[i]);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        do_restore(16, 1'b1, 1'b0, 1'b0, -1);   // preload 0x1000+i, back-to-back
        do_save(0, 1'b0, -1);
        do_save(1, 1'b0, -1);

        do_restore(16, 1'b1, 1'b1, 1'b1, -1);   // random data, random gaps
        do_save(2, 1'b0, -1);

        do_restore(6, 1'b1, 1'b0, 1'b1, -1);    // early in_last -> err
        do_save(2, 1'b0, -1);                   // clears err
        do_restore(16, 1'b0, 1'b1, 1'b1, -1);   // missing in_last -> err
        chk("err_sticky", err, 1);

        do_save(2, 1'b1, -1);                   // both requests, restore_req mid-save
        do_save(0, 1'b0, 7);                    // reset at beat 7
        do_save(0, 1'b0, -1);
        do_restore(16, 1'b1, 1'b1, 1'b1, 8);    // reset mid-restore
        do_save(1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
